// File: rtl/vga_pixel_pipe_if.sv
// vga_pixel_pipe_if: pattern controls into the pixel pipe, video timing and colour out of it.
interface vga_pixel_pipe_if #(parameter int COLOR_W = 8);
   logic [COLOR_W-1:0] sw;
   logic [1:0]         mode;
   logic               hsync, vsync, vga_clock, blank, sync, frame_start;
   logic [COLOR_W-1:0] red, green, blue;
   modport master (output sw, mode,
                   input hsync, vsync, vga_clock, blank, sync, frame_start, red, green, blue);
   modport slave  (input sw, mode,
                   output hsync, vsync, vga_clock, blank, sync, frame_start, red, green, blue);
endinterface

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: VGA timing generator feeding a two-stage colour pattern pipeline.
// Define VGA_PIX_TESTPAT_EN to build bars/checker/gradient modes; otherwise solid colour only.
module vga_pixel_pipe #(
   parameter int COLOR_W  = 8,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input logic clk,
   input logic reset,
   vga_pixel_pipe_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XC = $clog2(H_TOTAL);
   localparam int XM = (COLOR_W + 2 > 6) ? COLOR_W + 2 : 6;
   localparam int XW = (XC > XM) ? XC : XM;
   localparam int YC = $clog2(V_TOTAL);
   localparam int YW = (YC > 6) ? YC : 6;
   logic               vga_q, first_q, fs_q;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [COLOR_W-1:0] sw_q, sw_d;
   logic [COLOR_W-1:0] pr, pg, pb;
   logic [COLOR_W-1:0] r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
   logic               hs1_q, vs1_q, bl1_q, hs2_q, vs2_q, bl2_q;
   logic               tick, x_wrap, y_wrap, sof, hs_raw, vs_raw, bl_raw;
   assign tick   = vga_q;
   assign x_wrap = x_q == XW'(H_TOTAL - 1);
   assign y_wrap = y_q == YW'(V_TOTAL - 1);
   assign sof    = tick && x_q == '0 && y_q == '0;
   assign x_d    = x_wrap ? '0 : x_q + 1'b1;
   assign y_d    = !x_wrap ? y_q : (y_wrap ? '0 : y_q + 1'b1);
   // Shadows take the live inputs on the first tick of a frame so pixel (0,0) already sees them
   assign sw_d   = sof ? bus.sw : sw_q;
   assign hs_raw = !(x_q >= XW'(H_ACTIVE + H_FP) && x_q < XW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw = !(y_q >= YW'(V_ACTIVE + V_FP) && y_q < YW'(V_ACTIVE + V_FP + V_SYNC));
   assign bl_raw = x_q < XW'(H_ACTIVE) && y_q < YW'(V_ACTIVE);
`ifdef VGA_PIX_TESTPAT_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic [1:0]         mode_q, mode_d;
   logic [XW-1:0]      bar_idx;
   logic [2:0]         bar;
   logic [COLOR_W-1:0] grey;
   assign mode_d  = sof ? bus.mode : mode_q;
   assign bar_idx = x_q / XW'(BAR_W);
   assign bar     = bar_idx > XW'(7) ? 3'd7 : bar_idx[2:0];
   assign grey    = mode_d == 2'd2 ? ((x_q[5] ^ y_q[5]) ? '1 : sw_d) :
                    mode_d == 2'd3 ? x_q[COLOR_W+1:2] : sw_d;
   // Bar order white,yellow,cyan,green,magenta,red,blue,black reduces to inverted index bits
   assign pr = mode_d == 2'd1 ? {COLOR_W{~bar[1]}} : grey;
   assign pg = mode_d == 2'd1 ? {COLOR_W{~bar[2]}} : grey;
   assign pb = mode_d == 2'd1 ? {COLOR_W{~bar[0]}} : grey;
   always_ff @(posedge clk) begin
      if (!reset) mode_q <= '0;
      else if (tick) mode_q <= mode_d;
   end
`else
   assign pr = sw_d;
   assign pg = sw_d;
   assign pb = sw_d;
`endif
   always_ff @(posedge clk) begin
      if (!reset) begin
         vga_q   <= 1'b0;
         first_q <= 1'b1;
         fs_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         sw_q    <= '0;
         r1_q    <= '0;
         g1_q    <= '0;
         b1_q    <= '0;
         r2_q    <= '0;
         g2_q    <= '0;
         b2_q    <= '0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         bl1_q   <= 1'b0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
         bl2_q   <= 1'b0;
      end else begin
         vga_q   <= ~vga_q;
         first_q <= 1'b0;
         fs_q    <= tick ? (x_wrap && y_wrap) : first_q;
         if (tick) begin
            x_q   <= x_d;
            y_q   <= y_d;
            sw_q  <= sw_d;
            r1_q  <= pr;
            g1_q  <= pg;
            b1_q  <= pb;
            hs1_q <= hs_raw;
            vs1_q <= vs_raw;
            bl1_q <= bl_raw;
            r2_q  <= bl1_q ? r1_q : '0;
            g2_q  <= bl1_q ? g1_q : '0;
            b2_q  <= bl1_q ? b1_q : '0;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            bl2_q <= bl1_q;
         end
      end
   end
   assign bus.vga_clock   = vga_q;
   assign bus.frame_start = fs_q;
   assign bus.hsync       = hs2_q;
   assign bus.vsync       = vs2_q;
   assign bus.blank       = bl2_q;
   assign bus.sync        = 1'b0;
   assign bus.red         = r2_q;
   assign bus.green       = g2_q;
   assign bus.blue        = b2_q;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: randomized frames checked against a tick-count model of VGA timing and patterns.
`timescale 1ns/1ps
module tb_vga_pixel_pipe;
   localparam int CW = 8;
   localparam int HA = 128, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 36, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
   localparam int ONES = (1 << CW) - 1;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int compared = 0;
   int mismatched = 0;
   int n = 0;
   logic [CW-1:0] fr_sw[16];
   logic [1:0]    fr_mode[16];
   int bars[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
   vga_pixel_pipe_if #(.COLOR_W(CW)) bus ();
   vga_pixel_pipe #(
      .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0h expected %0h at clk %0d", tag, got, exp, n);
      end
   endtask
   // n counts clk edges since reset release; pixel index k-1 enters the pipe on tick k = n/2
   task automatic check_all();
      int q, f, p, x, y, m, s, c, r, g, b, hs, vs, act, fs;
      q = n / 2 - 2;
      r = 0; g = 0; b = 0; hs = 1; vs = 1; act = 0;
      if (q >= 0) begin
         f = q / FT; p = q % FT; x = p % HT; y = p / HT;
         m = int'(fr_mode[f]); s = int'(fr_sw[f]);
`ifndef VGA_PIX_TESTPAT_EN
         m = 0;
`endif
         act = (x < HA && y < VA) ? 1 : 0;
         hs = (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1;
         vs = (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1;
         if (act == 1) begin
            if (m == 0) begin
               r = s; g = s; b = s;
            end else if (m == 1) begin
               c = bars[x / (HA / 8)];
               r = (c & 4) != 0 ? ONES : 0;
               g = (c & 2) != 0 ? ONES : 0;
               b = (c & 1) != 0 ? ONES : 0;
            end else if (m == 2) begin
               r = ((x / 32 + y / 32) % 2 == 1) ? ONES : s; g = r; b = r;
            end else begin
               r = (x / 4) % (1 << CW); g = r; b = r;
            end
         end
      end
      fs = (n == 1 || (n > 0 && n % 2 == 0 && (n / 2) % FT == 0)) ? 1 : 0;
      chk("vga_clock", 32'(bus.vga_clock), 32'(n % 2));
      chk("frame_start", 32'(bus.frame_start), 32'(fs));
      chk("hsync", 32'(bus.hsync), 32'(hs));
      chk("vsync", 32'(bus.vsync), 32'(vs));
      chk("blank", 32'(bus.blank), 32'(act));
      chk("sync", 32'(bus.sync), 32'(0));
      chk("red", 32'(bus.red), 32'(r));
      chk("green", 32'(bus.green), 32'(g));
      chk("blue", 32'(bus.blue), 32'(b));
   endtask
   // Inputs change at negedge; frame settings are chosen just before the tick that starts each frame
   task automatic step();
      int k1, f;
      k1 = (n + 1) / 2;
      if (reset && (n + 1) % 2 == 0 && (k1 - 1) % FT == 0) begin
         f = (k1 - 1) / FT;
         bus.mode = 2'(f % 4);
         bus.sw = (f == 0) ? CW'(8'hA5) : (f == 2) ? '0 : CW'($urandom);
         fr_sw[f] = bus.sw;
         fr_mode[f] = bus.mode;
      end else if ($urandom_range(0, 299) == 0) begin
         bus.sw = CW'($urandom);
         bus.mode = 2'($urandom);
      end
      @(posedge clk);
      n = reset ? n + 1 : 0;
      @(negedge clk);
      check_all();
   endtask
   initial begin
      bus.sw = '0;
      bus.mode = '0;
      for (int i = 0; i < 16; i++) begin
         fr_sw[i] = '0;
         fr_mode[i] = '0;
      end
      repeat (3) step();
      reset = 1'b1;
      repeat (2 * (4 * FT + FT / 2)) step();
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      repeat (2 * (FT + 12)) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
